ball_flight: RTL and testbench
==============================

# ball_flight

Ball-trajectory stage directly downstream of the AI bowler. Accepts one delivery (`throw` plus per-frame step sizes `dy`/`dx`), advances the ball position once per frame tick, and samples the batter's swing. Each delivery is resolved to an outcome code that feeds the scoring and display logic.

## Interface
Parameters:
- `X_START`, 150: bowler-end x; reset and launch value of `ball_x`.
- `Y_START`, 20: launch height; reset value of `ball_y`.
- `X_WICKET`, 10: wicket line; a delivery resolves when `ball_x <= X_WICKET`.
- `HIT_WINDOW`, 8: a swing is valid while `X_WICKET <= ball_x <= X_WICKET+HIT_WINDOW`.
- `X_MAX`, 159: far boundary; the return flight ends at `ball_x >= X_MAX`.
- `Y_GROUND`, 100: ground level.
- `Y_STUMP`, 70: top of the stumps; a wicket requires `Y_STUMP <= ball_y <= Y_GROUND` at the line.
- `DONE_FRAMES`, 30: number of frame ticks the outcome is held.

Ports:
- `clock` in 1: single clock for the whole block.
- `reset` in 1: asynchronous, active-low reset.
- `gameOver` in 1: synchronous abort to IDLE.
- `frame_tick` in 1: one-cycle pulse once per frame.
- `throw` in 1: delivery request, level or pulse.
- `dy` in 4: vertical step per frame.
- `dx` in 4: horizontal step per frame.
- `bat_hit` in 1: batter swing, sampled only on `frame_tick` cycles.
- `ball_x` out 8: current ball x position.
- `ball_y` out 7: current ball y position.
- `ball_active` out 1: high in FLIGHT and RETURN.
- `ready` out 1: high in IDLE only.
- `outcome` out 2: 00 NONE, 01 WICKET, 10 MISS, 11 RUNS.
- `outcome_valid` out 1: high throughout DONE.

## Operation
- Reset values: `ball_x=X_START`, `ball_y=Y_START`, `ball_active=0`, `ready=1`, `outcome=00`, `outcome_valid=0`, state IDLE.
- **IDLE**: on `throw=1`, the block latches `dx` and `dy`, loads the start position, and enters FLIGHT. If `dx==0`, it latches 1 instead, so the ball cannot stall. `throw` is ignored in all other states.
- **FLIGHT**, on each `frame_tick`, in priority order:
  1. If `bat_hit` is high and the current (pre-update) `ball_x` is inside the hit window: go to RETURN and set `x = x + 2*dx` on this same tick.
  2. Otherwise: `x = max(x - dx, 0)`; `y = y + dy`, with ground handling per Configuration.
  3. If the new `x <= X_WICKET`: set `outcome` to WICKET if the new y is in `[Y_STUMP, Y_GROUND]`, else MISS. Go to DONE.
- **RETURN**, on each `frame_tick`: `x = min(x + 2*dx, X_MAX)`; y is frozen. When `x == X_MAX`, set `outcome` to RUNS and go to DONE.
- **DONE**: `outcome_valid=1`, position frozen. The block counts `DONE_FRAMES` ticks, then returns to IDLE, clears `outcome` to 00, and restores the start position.
- `bat_hit` outside the hit window, or in any state other than FLIGHT, is ignored.
- `gameOver=1` in any state: on the next edge, all outputs return to their reset values. `gameOver` has priority over `throw` and `frame_tick`.
- Arithmetic is done at 9 bits, then saturated to 8 (x) or 7 (y) bits. No wrap-around is permitted.

## Timing
- `throw` sampled in IDLE: the next cycle shows FLIGHT, `ready=0`, `ball_active=1`, and position equal to the start values.
- The position changes only on the edge that samples `frame_tick=1`; outputs are registered, so the new position is visible in the following cycle.
- The outcome is registered on the same edge as the resolving position update. `outcome_valid` rises on that edge.
- `ready` rises on the edge that ends DONE. A `throw` held high is accepted on the following cycle.
- Asynchronous `reset` mid-flight clears everything immediately. No delivery state survives reset.

## Configuration
- `BALL_BOUNCE_EN` defined: when `y + dy >= Y_GROUND`, set y to `Y_GROUND` and invert the vertical direction. Subsequent ticks apply `y = max(y - dy, 0)`. Only one bounce is allowed per delivery.
- Undefined: y saturates at `Y_GROUND` and stays there.

## Structure
- Package `cricket_pkg`:
  - state enum (IDLE, FLIGHT, RETURN, DONE);
  - outcome codes;
  - coordinate widths (`X_W=8`, `Y_W=7`).
- Sub-module `ball_step`: combinational saturating next-position and hit-window compare. It is instantiated once. The FSM, latched `dx`/`dy`, and DONE counter live in `ball_flight`.

## Test plan
- Wicket: `throw`, dx=4, dy=2, no swing. After 35 ticks, x=10 and y=90; then `outcome=01` and `outcome_valid=1` for 30 ticks, after which `ready=1`.
- Miss: dx=4, dy=1. At tick 35, x=10 and y=55; `outcome=10`.
- Hit: dx=4, dy=2, `bat_hit` on tick 34 (x=18). The next x is 26, then +8 per tick. After 17 more ticks, x=159 and `outcome=11`.
- Zero step: dx=0, dy=0. x decrements by 1 per tick and resolves at tick 140 with y=20, giving `outcome=10`.
- Abort: `gameOver` at tick 10 in FLIGHT. The next cycle shows x=150, y=20, `ready=1`, `ball_active=0`. Repeat with `reset` low: same values, asynchronously.
- Bounce: dx=2, dy=4. y reaches 100 at tick 20 (x=110).
  - With `BALL_BOUNCE_EN`: y falls to 0 by tick 45; at tick 70 (x=10), `outcome=10`.
  - Without the macro: y holds at 100; `outcome=01`.

Source files
------------

// File: rtl/cricket_pkg.sv
// Shared types and coordinate widths for the ball-trajectory stage.
package cricket_pkg;

    localparam int unsigned X_W = 8;
    localparam int unsigned Y_W = 7;

    typedef enum logic [1:0] {
        StIdle,
        StFlight,
        StReturn,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        OutNone   = 2'b00,
        OutWicket = 2'b01,
        OutMiss   = 2'b10,
        OutRuns   = 2'b11
    } outcome_e;

endpackage

// File: rtl/ball_flight_if.sv
// Delivery/frame/swing inputs and ball/outcome outputs of the trajectory stage.
interface ball_flight_if;
    import cricket_pkg::*;

    logic           gameOver;
    logic           frame_tick;
    logic           throw;
    logic [3:0]     dy;
    logic [3:0]     dx;
    logic           bat_hit;
    logic [X_W-1:0] ball_x;
    logic [Y_W-1:0] ball_y;
    logic           ball_active;
    logic           ready;
    outcome_e       outcome;
    logic           outcome_valid;

    // Bowler / game side.
    modport master (
        output gameOver, frame_tick, throw, dy, dx, bat_hit,
        input  ball_x, ball_y, ball_active, ready, outcome, outcome_valid
    );

    // Trajectory stage side.
    modport slave (
        input  gameOver, frame_tick, throw, dy, dx, bat_hit,
        output ball_x, ball_y, ball_active, ready, outcome, outcome_valid
    );

endinterface

// File: rtl/ball_step.sv
// Combinational next-position candidates (saturating, 9-bit intermediate) and
// hit-window compare for the current ball position.
module ball_step
    import cricket_pkg::*;
#(
    parameter int unsigned X_WICKET   = 10,
    parameter int unsigned HIT_WINDOW = 8,
    parameter int unsigned X_MAX      = 159,
    parameter int unsigned Y_GROUND   = 100
) (
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] y,
    input  logic [3:0]     dx,
    input  logic [3:0]     dy,
    input  logic           falling,
    output logic [X_W-1:0] fwd_x,
    output logic [X_W-1:0] back_x,
    output logic [Y_W-1:0] next_y,
    output logic           bounce,
    output logic           in_window
);

    logic [8:0] x9, y9, dx9, dy9, back_sum, y_sum;

    // Saturating arithmetic: x toward the wicket, x on the return flight, y per frame.
    always_comb begin
        x9       = 9'(x);
        y9       = 9'(y);
        dx9      = 9'(dx);
        dy9      = 9'(dy);
        fwd_x    = (x9 < dx9) ? '0 : X_W'(x9 - dx9);
        back_sum = x9 + (dx9 << 1);
        back_x   = (back_sum >= 9'(X_MAX)) ? X_W'(X_MAX) : X_W'(back_sum);
        y_sum    = y9 + dy9;
        bounce   = 1'b0;
        if (falling) begin
            next_y = (y9 < dy9) ? '0 : Y_W'(y9 - dy9);
        end else if (y_sum >= 9'(Y_GROUND)) begin
            // Pinned at ground; caller decides whether this flips direction.
            next_y = Y_W'(Y_GROUND);
            bounce = 1'b1;
        end else begin
            next_y = Y_W'(y_sum);
        end
        in_window = (x9 >= 9'(X_WICKET)) && (x9 <= 9'(X_WICKET + HIT_WINDOW));
    end

endmodule

// File: rtl/ball_flight.sv
// Ball-trajectory stage: accepts a delivery, advances the ball once per frame
// tick, samples the swing and resolves the delivery to an outcome code.
// Optional feature: define BALL_BOUNCE_EN to let the ball bounce once off the
// ground per delivery; otherwise y saturates at ground level.
module ball_flight
    import cricket_pkg::*;
#(
    parameter int unsigned X_START     = 150,
    parameter int unsigned Y_START     = 20,
    parameter int unsigned X_WICKET    = 10,
    parameter int unsigned HIT_WINDOW  = 8,
    parameter int unsigned X_MAX       = 159,
    parameter int unsigned Y_GROUND    = 100,
    parameter int unsigned Y_STUMP     = 70,
    parameter int unsigned DONE_FRAMES = 30
) (
    input  logic         clock,
    input  logic         reset,
    ball_flight_if.slave bus
);

`ifdef BALL_BOUNCE_EN
    localparam bit BOUNCE_EN = 1'b1;
`else
    localparam bit BOUNCE_EN = 1'b0;
`endif

    localparam int unsigned CNT_W = $clog2(DONE_FRAMES + 1);

    state_e         state;
    logic [X_W-1:0] pos_x;
    logic [Y_W-1:0] pos_y;
    logic [3:0]     step_dx;
    logic [3:0]     step_dy;
    logic           falling;
    logic [CNT_W-1:0] done_cnt;
    outcome_e       out_code;
    logic           active;
    logic           rdy;
    logic           valid;

    logic [X_W-1:0] fwd_x;
    logic [X_W-1:0] back_x;
    logic [Y_W-1:0] next_y;
    logic           bounce;
    logic           in_window;
    logic           at_line;
    logic           at_stumps;

    ball_step #(
        .X_WICKET   (X_WICKET),
        .HIT_WINDOW (HIT_WINDOW),
        .X_MAX      (X_MAX),
        .Y_GROUND   (Y_GROUND)
    ) u_step (
        .x         (pos_x),
        .y         (pos_y),
        .dx        (step_dx),
        .dy        (step_dy),
        .falling   (falling),
        .fwd_x     (fwd_x),
        .back_x    (back_x),
        .next_y    (next_y),
        .bounce    (bounce),
        .in_window (in_window)
    );

    assign at_line   = 9'(fwd_x) <= 9'(X_WICKET);
    assign at_stumps = (9'(next_y) >= 9'(Y_STUMP)) && (9'(next_y) <= 9'(Y_GROUND));

    // Delivery FSM: launch, per-tick flight and return, outcome hold, abort.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= StIdle;
            pos_x    <= X_W'(X_START);
            pos_y    <= Y_W'(Y_START);
            step_dx  <= 4'd1;
            step_dy  <= 4'd0;
            falling  <= 1'b0;
            done_cnt <= '0;
            out_code <= OutNone;
            active   <= 1'b0;
            rdy      <= 1'b1;
            valid    <= 1'b0;
        end else if (bus.gameOver) begin
            state    <= StIdle;
            pos_x    <= X_W'(X_START);
            pos_y    <= Y_W'(Y_START);
            step_dx  <= 4'd1;
            step_dy  <= 4'd0;
            falling  <= 1'b0;
            done_cnt <= '0;
            out_code <= OutNone;
            active   <= 1'b0;
            rdy      <= 1'b1;
            valid    <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (bus.throw) begin
                        // A zero dx would leave the ball hanging forever.
                        step_dx <= (bus.dx == 4'd0) ? 4'd1 : bus.dx;
                        step_dy <= bus.dy;
                        pos_x   <= X_W'(X_START);
                        pos_y   <= Y_W'(Y_START);
                        falling <= 1'b0;
                        state   <= StFlight;
                        rdy     <= 1'b0;
                        active  <= 1'b1;
                    end
                end
                StFlight: begin
                    if (bus.frame_tick) begin
                        if (bus.bat_hit && in_window) begin
                            pos_x <= back_x;
                            state <= StReturn;
                        end else begin
                            pos_x <= fwd_x;
                            pos_y <= next_y;
                            if (BOUNCE_EN && bounce) begin
                                falling <= 1'b1;
                            end
                            if (at_line) begin
                                out_code <= at_stumps ? OutWicket : OutMiss;
                                state    <= StDone;
                                active   <= 1'b0;
                                valid    <= 1'b1;
                                done_cnt <= '0;
                            end
                        end
                    end
                end
                StReturn: begin
                    if (bus.frame_tick) begin
                        pos_x <= back_x;
                        if (back_x == X_W'(X_MAX)) begin
                            out_code <= OutRuns;
                            state    <= StDone;
                            active   <= 1'b0;
                            valid    <= 1'b1;
                            done_cnt <= '0;
                        end
                    end
                end
                StDone: begin
                    if (bus.frame_tick) begin
                        if (done_cnt == CNT_W'(DONE_FRAMES - 1)) begin
                            state    <= StIdle;
                            out_code <= OutNone;
                            valid    <= 1'b0;
                            rdy      <= 1'b1;
                            pos_x    <= X_W'(X_START);
                            pos_y    <= Y_W'(Y_START);
                        end else begin
                            done_cnt <= done_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.ball_x        = pos_x;
    assign bus.ball_y        = pos_y;
    assign bus.ball_active   = active;
    assign bus.ready         = rdy;
    assign bus.outcome       = out_code;
    assign bus.outcome_valid = valid;

endmodule

// File: tb/tb_ball_flight.sv
// Self-checking bench for ball_flight: directed deliveries from the test plan
// plus randomized deliveries, checked against a tick-level integer model.
module tb_ball_flight;

    localparam int X_START     = 150;
    localparam int Y_START     = 20;
    localparam int X_WICKET    = 10;
    localparam int HIT_WINDOW  = 8;
    localparam int X_MAX       = 159;
    localparam int Y_GROUND    = 100;
    localparam int Y_STUMP     = 70;
    localparam int DONE_FRAMES = 30;
`ifdef BALL_BOUNCE_EN
    localparam int BOUNCE = 1;
`else
    localparam int BOUNCE = 0;
`endif

    localparam int PH_IDLE = 0, PH_FLIGHT = 1, PH_RETURN = 2, PH_DONE = 3;

    logic clock = 1'b0;
    logic reset;
    ball_flight_if bus ();

    ball_flight dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    int mph, mx, my, mdx, mdy, mfall, mout, mcnt;

    // Per-delivery observations
    int hist_x [0:400];
    int hist_y [0:400];
    int r_tick, r_out, r_idle;

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        mph = PH_IDLE; mx = X_START; my = Y_START; mout = 0; mfall = 0; mcnt = 0;
    endtask

    task automatic m_start(input int ddx, input int ddy);
        mdx = (ddx == 0) ? 1 : ddx;
        mdy = ddy;
        mx = X_START; my = Y_START; mfall = 0; mout = 0; mph = PH_FLIGHT;
    endtask

    task automatic m_tick(input bit hit);
        int pre;
        case (mph)
            PH_FLIGHT: begin
                pre = mx;
                if (hit && pre >= X_WICKET && pre <= X_WICKET + HIT_WINDOW) begin
                    mx = min_i(pre + 2 * mdx, X_MAX);
                    mph = PH_RETURN;
                end else begin
                    mx = max_i(pre - mdx, 0);
                    if (mfall != 0) my = max_i(my - mdy, 0);
                    else if (my + mdy >= Y_GROUND) begin
                        my = Y_GROUND;
                        mfall = BOUNCE;
                    end else my = my + mdy;
                    if (mx <= X_WICKET) begin
                        mout = (my >= Y_STUMP && my <= Y_GROUND) ? 1 : 2;
                        mph = PH_DONE;
                        mcnt = 0;
                    end
                end
            end
            PH_RETURN: begin
                mx = min_i(mx + 2 * mdx, X_MAX);
                if (mx == X_MAX) begin
                    mout = 3;
                    mph = PH_DONE;
                    mcnt = 0;
                end
            end
            PH_DONE: begin
                mcnt++;
                if (mcnt == DONE_FRAMES) m_reset();
            end
            default: ;
        endcase
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".x"},      32'(bus.ball_x), mx);
        check({tag, ".y"},      32'(bus.ball_y), my);
        check({tag, ".ready"},  32'(bus.ready), (mph == PH_IDLE) ? 1 : 0);
        check({tag, ".active"}, 32'(bus.ball_active),
              (mph == PH_FLIGHT || mph == PH_RETURN) ? 1 : 0);
        check({tag, ".valid"},  32'(bus.outcome_valid), (mph == PH_DONE) ? 1 : 0);
        check({tag, ".out"},    32'(bus.outcome), mout);
    endtask

    task automatic launch(input int ddx, input int ddy);
        @(negedge clock);
        bus.throw = 1'b1;
        bus.dx = 4'(ddx);
        bus.dy = 4'(ddy);
        @(posedge clock);
        #1;
        bus.throw = 1'b0;
        m_start(ddx, ddy);
        check_outputs("launch");
    endtask

    // swing: >0 swing on that tick only, 0 random swings in the window, -1 never.
    // hold: keep throw high through DONE so the next delivery is taken at once.
    task automatic fly(input int swing, input bit hold, input int limit, input bit expect_end);
        int t;
        bit hit, inwin;
        t = 0; r_tick = -1; r_idle = -1; r_out = -1;
        while (mph != PH_IDLE && t < limit) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clock);
                #1;
                check_outputs("gap");
            end
            @(negedge clock);
            t++;
            inwin = (mph == PH_FLIGHT) && mx >= X_WICKET && mx <= X_WICKET + HIT_WINDOW;
            if (swing > 0) hit = (t == swing);
            else if (swing == 0 && inwin) hit = ($urandom_range(0, 2) == 0);
            else hit = 1'b0;
            if (!inwin) hit = hit | ($urandom_range(0, 3) == 0);
            bus.frame_tick = 1'b1;
            bus.bat_hit = hit;
            bus.dx = 4'($urandom);
            bus.dy = 4'($urandom);
            if (hold) bus.throw = (mph == PH_DONE);
            else bus.throw = (mph == PH_FLIGHT || mph == PH_RETURN) && ($urandom_range(0, 1) == 1);
            @(posedge clock);
            #1;
            bus.frame_tick = 1'b0;
            bus.bat_hit = 1'b0;
            if (!hold) bus.throw = 1'b0;
            m_tick(hit);
            check_outputs("tick");
            hist_x[t] = int'(bus.ball_x);
            hist_y[t] = int'(bus.ball_y);
            if (r_tick < 0 && bus.outcome_valid === 1'b1) begin
                r_tick = t;
                r_out = int'(bus.outcome);
            end
            if (r_idle < 0 && r_tick >= 0 && bus.ready === 1'b1) r_idle = t;
        end
        if (expect_end) check("delivery_end.ready", 32'(bus.ready), 1);
    endtask

    initial begin
        reset = 1'b0;
        bus.gameOver = 1'b0;
        bus.frame_tick = 1'b0;
        bus.throw = 1'b0;
        bus.dx = 4'd0;
        bus.dy = 4'd0;
        bus.bat_hit = 1'b0;
        m_reset();
        #12;
        check_outputs("reset");
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_outputs("post_reset");

        // Wicket
        launch(4, 2);
        fly(-1, 1'b0, 400, 1'b1);
        check("wkt.x35", 32'(hist_x[35]), 10);
        check("wkt.y35", 32'(hist_y[35]), 90);
        check("wkt.tick", 32'(r_tick), 35);
        check("wkt.out", 32'(r_out), 1);
        check("wkt.hold", 32'(r_idle - r_tick), DONE_FRAMES);

        // Miss
        launch(4, 1);
        fly(-1, 1'b0, 400, 1'b1);
        check("miss.x35", 32'(hist_x[35]), 10);
        check("miss.y35", 32'(hist_y[35]), 55);
        check("miss.out", 32'(r_out), 2);

        // Hit on tick 34 from x=18
        launch(4, 2);
        fly(34, 1'b0, 400, 1'b1);
        check("hit.x33", 32'(hist_x[33]), 18);
        check("hit.x34", 32'(hist_x[34]), 26);
        check("hit.x35", 32'(hist_x[35]), 34);
        check("hit.x51", 32'(hist_x[51]), 159);
        check("hit.tick", 32'(r_tick), 51);
        check("hit.out", 32'(r_out), 3);

        // Zero step
        launch(0, 0);
        fly(-1, 1'b0, 400, 1'b1);
        check("zero.x1", 32'(hist_x[1]), 149);
        check("zero.tick", 32'(r_tick), 140);
        check("zero.y140", 32'(hist_y[140]), 20);
        check("zero.out", 32'(r_out), 2);

        // Ground contact
        launch(2, 4);
        fly(-1, 1'b0, 400, 1'b1);
        check("bnc.x20", 32'(hist_x[20]), 110);
        check("bnc.y20", 32'(hist_y[20]), 100);
        check("bnc.tick", 32'(r_tick), 70);
`ifdef BALL_BOUNCE_EN
        check("bnc.y45", 32'(hist_y[45]), 0);
        check("bnc.out", 32'(r_out), 2);
`else
        check("bnc.y45", 32'(hist_y[45]), 100);
        check("bnc.out", 32'(r_out), 1);
`endif

        // Held throw is taken the cycle after DONE ends, then abort at tick 10
        launch(6, 1);
        fly(0, 1'b1, 400, 1'b1);
        bus.dx = 4'd3;
        bus.dy = 4'd5;
        @(posedge clock);
        #1;
        bus.throw = 1'b0;
        m_start(3, 5);
        check_outputs("held_accept");
        fly(-1, 1'b0, 10, 1'b0);
        check("abort.x10", 32'(hist_x[10]), 120);
        check("abort.y10", 32'(hist_y[10]), 70);
        @(negedge clock);
        bus.gameOver = 1'b1;
        bus.throw = 1'b1;
        bus.frame_tick = 1'b1;
        bus.bat_hit = 1'b1;
        @(posedge clock);
        #1;
        bus.gameOver = 1'b0;
        bus.throw = 1'b0;
        bus.frame_tick = 1'b0;
        bus.bat_hit = 1'b0;
        m_reset();
        check_outputs("abort");
        check("abort.x", 32'(bus.ball_x), 150);
        check("abort.ready", 32'(bus.ready), 1);
        @(posedge clock);
        #1;
        check_outputs("abort_settle");

        // Asynchronous reset mid-flight
        launch(5, 3);
        fly(-1, 1'b0, 12, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        m_reset();
        check_outputs("async");
        check("async.x", 32'(bus.ball_x), 150);
        check("async.active", 32'(bus.ball_active), 0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_outputs("after_async");

        // Randomized deliveries
        for (int i = 0; i < 8; i++) begin
            launch(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            fly(0, 1'b0, 400, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
